vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 640x480 sync generator. Adds:
- configurable porch/sync geometry and sync polarity;
- a pixel clock-enable for divided clocks;
- a synchronous frame counter, replacing the vsync-clocked counter;
- a programmable pipeline delay that aligns sync/blank with downstream pixel-math latency;
- line/frame start strobes.
Sits between the clock/reset and the pixel shader logic; its outputs drive the TinyVGA PMOD directly.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync level while in sync (0 = active-low)
- VSYNC_POL, 0, vsync level while in sync (0 = active-low)
- PIPE, 1, delay in ce-advances from the counters to the sync/blank/strobe outputs (legal range 1..4)
- FRAME_W, 12, frame counter width

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  synchronous active-low reset
- ce  in  1  pixel clock enable; counters and pipeline advance only when 1
- hpos  out  10  current horizontal counter (undelayed)
- vpos  out  10  current vertical counter (undelayed)
- hsync  out  1  horizontal sync, polarity per HSYNC_POL, delayed PIPE
- vsync  out  1  vertical sync, polarity per VSYNC_POL, delayed PIPE
- display_on  out  1  1 inside the visible area, delayed PIPE
- line_start  out  1  one-clk pulse marking hpos==0 of every line, delayed PIPE
- frame_start  out  1  one-clk pulse marking hpos==0 && vpos==0, delayed PIPE
- frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL analogous.
  - Region order per axis: display, front porch, sync, back porch.
- Reset (rst_n=0 at a clk edge, regardless of ce), values after that edge:
  - hpos=0, vpos=0, frame_cnt=0.
  - All pipeline stages hold the inactive tag: hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_on=0, line_start=0, frame_start=0.
  - Reset mid-frame abandons the frame with no partial-frame increment.
- Counters (ce=1 edge):
  - hpos==H_TOTAL-1 -> hpos=0, else hpos+1.
  - On the hpos wrap: vpos==V_TOTAL-1 -> vpos=0 and frame_cnt+1 (modulo 2^FRAME_W), else vpos+1.
  - ce=0 -> all state holds.
- Decode (from the current counters):
  - hs_act = hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vs_act analogous on vpos.
  - vis = hpos<H_DISPLAY && vpos<V_DISPLAY.
  - ls = hpos==0.
  - fs = ls && vpos==0.
- Pipeline:
  - PIPE-deep shift register of {hs_act, vs_act, vis, ls, fs}; shifts only on ce=1.
  - Output stage reflects the decode of the counter value PIPE ce-advances earlier.
- Output mapping:
  - hsync = hs_act_d ? HSYNC_POL : ~HSYNC_POL; vsync likewise with VSYNC_POL.
  - display_on = vis_d.
- Strobes:
  - line_start = ls_d && shifted, where "shifted" is a register set on each ce=1 edge and cleared otherwise.
  - This gives exactly one clk high per line even with sparse ce; frame_start likewise.
- frame_cnt and hpos/vpos are undelayed. Shaders use hpos/vpos at stage 0 and must match PIPE to their own latency.
- Elaboration: PIPE outside 1..4, or H_TOTAL/V_TOTAL > 1024, is a fatal error.

Test Plan:
- Reset then ce=1 constantly, defaults -> hsync low exactly for hpos 656..751 (96 clks, seen one clk later, PIPE=1); line period 800 clks; vsync low for vpos 490..491 (1600 clks); display_on high 640 clks/line on lines 0..479.
- Run 3 full frames -> frame_cnt=3; frame_start pulses every 420000 clks, one clk wide, coincident with the line_start pulse; 525 line_start pulses per frame.
- ce toggling 1/0 every clk (half-rate) -> line period 1600 clks; line_start still exactly 1 clk wide; hold cycles never change any output.
- PIPE=3, HSYNC_POL=1 -> hsync high when the counter was 656 three ce-advances earlier; display_on falls 3 clks after hpos reaches 640.
- Assert rst_n=0 for 1 clk at hpos=300, vpos=200 -> next cycle hpos=0, vpos=0, frame_cnt unchanged-then-0, hsync/vsync inactive, display_on=0; counting resumes from 0.
- FRAME_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1 (wrap-around).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with
// pixel ce, frame counter and latency-matched sync/blank/strobes.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE      = 1,
  parameter int FRAME_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $fatal(1, "vga_timing_gen: PIPE must be 1..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic ls;
    logic fs;
  } tag_t;

  logic h_wrap;
  logic v_wrap;
  tag_t tag;
  tag_t tag_d;
  tag_t pipe_q [PIPE];
  logic shifted;

  assign h_wrap = (hpos == H_LAST);
  assign v_wrap = (vpos == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos      <= '0;
      vpos      <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      hpos <= h_wrap ? 10'd0 : hpos + 10'd1;
      if (h_wrap) begin
        vpos <= v_wrap ? 10'd0 : vpos + 10'd1;
        if (v_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    tag     = '0;
    tag.hs  = (hpos >= HS_LO) && (hpos <= HS_HI);
    tag.vs  = (vpos >= VS_LO) && (vpos <= VS_HI);
    tag.vis = (hpos < H_VIS) && (vpos < V_VIS);
    tag.ls  = (hpos == 10'd0);
    tag.fs  = (hpos == 10'd0) && (vpos == 10'd0);
  end

  // An all-zero tag decodes to inactive sync, blank and no strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
      shifted <= 1'b0;
    end else begin
      shifted <= ce;
      if (ce) begin
        pipe_q[0] <= tag;
        for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_d = pipe_q[PIPE-1];

  assign hsync       = tag_d.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = tag_d.vs ? VSYNC_POL : ~VSYNC_POL;
  assign display_on  = tag_d.vis;
  // Gating with shifted keeps strobes one clk wide under sparse ce.
  assign line_start  = tag_d.ls && shifted;
  assign frame_start = tag_d.fs && shifted;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four parameter sets of vga_timing_gen checked
// cycle by cycle against a closed-form expectation queue.
module tb_vga_timing_gen;

  localparam int SHD = 8;
  localparam int SHF = 2;
  localparam int SHW = 3;
  localparam int SHB = 2;
  localparam int SVD = 6;
  localparam int SVF = 1;
  localparam int SVW = 2;
  localparam int SVB = 2;
  localparam int SFR = 165;

  typedef struct packed {
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] fc;
  } obs_t;

  typedef obs_t [3:0] exp_set_t;

  logic clk;
  logic rst_n;
  logic ce;

  logic [9:0]  hp [4];
  logic [9:0]  vp [4];
  logic        hs [4];
  logic        vs [4];
  logic        de [4];
  logic        ls [4];
  logic        fs [4];
  logic [11:0] fc0, fc1, fc2;
  logic [1:0]  fc3;

  obs_t     act [4];
  exp_set_t cur;
  exp_set_t exp_q [$];

  int errors = 0;
  int checks = 0;
  int n_q = 0;

  localparam obs_t RST_LOWPOL = '{hpos: 10'd0, vpos: 10'd0,
    hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, fc: 12'd0};

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(hp[0]), .vpos(vp[0]), .hsync(hs[0]), .vsync(vs[0]),
    .display_on(de[0]), .line_start(ls[0]), .frame_start(fs[0]),
    .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHW), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVW), .V_BACK(SVB)
  ) u_sm (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(hp[1]), .vpos(vp[1]), .hsync(hs[1]), .vsync(vs[1]),
    .display_on(de[1]), .line_start(ls[1]), .frame_start(fs[1]),
    .frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHW), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVW), .V_BACK(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(3)
  ) u_p3 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(hp[2]), .vpos(vp[2]), .hsync(hs[2]), .vsync(vs[2]),
    .display_on(de[2]), .line_start(ls[2]), .frame_start(fs[2]),
    .frame_cnt(fc2)
  );

  vga_timing_gen #(
    .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHW), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVW), .V_BACK(SVB),
    .FRAME_W(2)
  ) u_fw (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(hp[3]), .vpos(vp[3]), .hsync(hs[3]), .vsync(vs[3]),
    .display_on(de[3]), .line_start(ls[3]), .frame_start(fs[3]),
    .frame_cnt(fc3)
  );

  assign act[0] = {hp[0], vp[0], hs[0], vs[0], de[0], ls[0], fs[0], fc0};
  assign act[1] = {hp[1], vp[1], hs[1], vs[1], de[1], ls[1], fs[1], fc1};
  assign act[2] = {hp[2], vp[2], hs[2], vs[2], de[2], ls[2], fs[2], fc2};
  assign act[3] = {hp[3], vp[3], hs[3], vs[3], de[3], ls[3], fs[3],
                   {10'd0, fc3}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state after n ce-advances since reset, adv = ce at last edge.
  function automatic obs_t predict(
    input int n, input bit adv,
    input int hd, hf, hw, hb, vd, vf, vw, vb,
    input int pipe, input bit hpl, input bit vpl, input int fw);
    obs_t o;
    int ht, vt, m, h, v;
    ht = hd + hf + hw + hb;
    vt = vd + vf + vw + vb;
    o.hpos = 10'(n % ht);
    o.vpos = 10'((n / ht) % vt);
    o.fc = 12'((n / (ht * vt)) % (1 << fw));
    o.hs = ~hpl;
    o.vs = ~vpl;
    o.de = 1'b0;
    o.ls = 1'b0;
    o.fs = 1'b0;
    if (n >= pipe) begin
      m = n - pipe;
      h = m % ht;
      v = (m / ht) % vt;
      if (h >= hd + hf && h < hd + hf + hw) o.hs = hpl;
      if (v >= vd + vf && v < vd + vf + vw) o.vs = vpl;
      o.de = (h < hd) && (v < vd);
      o.ls = (h == 0) && adv;
      o.fs = (h == 0) && adv && (v == 0);
    end
    return o;
  endfunction

  function automatic obs_t exp_for(input int k, input int n, input bit adv);
    if (k == 0)
      return predict(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 0, 12);
    if (k == 1)
      return predict(n, adv, SHD, SHF, SHW, SHB, SVD, SVF, SVW, SVB,
                     1, 0, 0, 12);
    if (k == 2)
      return predict(n, adv, SHD, SHF, SHW, SHB, SVD, SVF, SVW, SVB,
                     3, 1, 1, 12);
    return predict(n, adv, SHD, SHF, SHW, SHB, SVD, SVF, SVW, SVB,
                   1, 0, 0, 2);
  endfunction

  always @(posedge clk) begin
    exp_set_t s;
    int nn;
    bit na;
    nn = n_q;
    na = 1'b0;
    if (!rst_n) begin
      nn = 0;
    end else if (ce) begin
      nn = n_q + 1;
      na = 1'b1;
    end
    for (int k = 0; k < 4; k++) s[k] = exp_for(k, nn, na);
    exp_q.push_back(s);
    n_q <= nn;
  end

  task automatic tick();
    @(negedge clk);
    cur = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act[k] !== cur[k]) begin
        errors++;
        $display("FAIL reset_model inst=%0d got=%h want=%h", k, act[k], cur[k]);
      end
    end
    checks++;
    if (act[1] !== RST_LOWPOL) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", act[1], RST_LOWPOL);
    end
    checks++;
    if (act[2].hs !== 1'b0 || act[2].vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_highpol hs=%b vs=%b want 0 0", act[2].hs, act[2].vs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default_line();
    int hs_lo = 0;
    int de_hi = 0;
    int ls_n = 0;
    int first_hs = -1;
    ce = 1'b1;
    for (int c = 0; c < 800; c++) begin
      tick();
      checks++;
      if (act[0] !== cur[0]) begin
        errors++;
        $display("FAIL default_line c=%0d got=%h want=%h", c, act[0], cur[0]);
      end
      if (act[0].hs === 1'b0) begin
        hs_lo++;
        if (first_hs < 0) first_hs = int'(act[0].hpos);
      end
      if (act[0].de === 1'b1) de_hi++;
      if (act[0].ls === 1'b1) ls_n++;
    end
    checks++;
    if (hs_lo != 96) begin
      errors++;
      $display("FAIL hsync_width got=%0d want=96", hs_lo);
    end
    checks++;
    if (first_hs != 657) begin
      errors++;
      $display("FAIL hsync_start hpos got=%0d want=657", first_hs);
    end
    checks++;
    if (de_hi != 640) begin
      errors++;
      $display("FAIL display_width got=%0d want=640", de_hi);
    end
    checks++;
    if (ls_n != 1) begin
      errors++;
      $display("FAIL default_ls_count got=%0d want=1", ls_n);
    end
  endtask

  task automatic test_frames();
    int fs_n = 0;
    int ls_n = 0;
    int vs_lo = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    for (int c = 0; c < 3 * SFR; c++) begin
      tick();
      checks++;
      if (act[1] !== cur[1]) begin
        errors++;
        $display("FAIL frames c=%0d got=%h want=%h", c, act[1], cur[1]);
      end
      checks++;
      if (act[1].fs === 1'b1 && act[1].ls !== 1'b1) begin
        errors++;
        $display("FAIL fs_with_ls c=%0d ls=%b want 1", c, act[1].ls);
      end
      if (act[1].fs === 1'b1) fs_n++;
      if (act[1].ls === 1'b1) ls_n++;
      if (act[1].vs === 1'b0) vs_lo++;
    end
    checks++;
    if (act[1].fc !== 12'd3) begin
      errors++;
      $display("FAIL frame_cnt got=%0d want=3", act[1].fc);
    end
    checks++;
    if (fs_n != 3) begin
      errors++;
      $display("FAIL frame_start_count got=%0d want=3", fs_n);
    end
    checks++;
    if (ls_n != 33) begin
      errors++;
      $display("FAIL line_start_count got=%0d want=33", ls_n);
    end
    checks++;
    if (vs_lo != 90) begin
      errors++;
      $display("FAIL vsync_width got=%0d want=90", vs_lo);
    end
  endtask

  task automatic test_frame_wrap();
    int want [5] = '{1, 2, 3, 0, 1};
    int seq [8];
    int ns = 0;
    logic [11:0] last;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    last = act[3].fc;
    for (int c = 0; c < 5 * SFR; c++) begin
      tick();
      checks++;
      if (act[3] !== cur[3]) begin
        errors++;
        $display("FAIL wrap_model c=%0d got=%h want=%h", c, act[3], cur[3]);
      end
      if (act[3].fc !== last) begin
        if (ns < 8) seq[ns] = int'(act[3].fc);
        ns++;
        last = act[3].fc;
      end
    end
    checks++;
    if (ns != 5) begin
      errors++;
      $display("FAIL wrap_changes got=%0d want=5", ns);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i < ns && seq[i] != want[i]) begin
        errors++;
        $display("FAIL wrap_seq i=%0d got=%0d want=%0d", i, seq[i], want[i]);
      end
    end
  endtask

  task automatic test_half_rate();
    int first = -1;
    int second = -1;
    int run = 0;
    int max_run = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    for (int c = 0; c < 3400; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== cur[k]) begin
          errors++;
          $display("FAIL half_rate c=%0d inst=%0d got=%h want=%h",
                   c, k, act[k], cur[k]);
        end
      end
      if (act[0].ls === 1'b1) begin
        run++;
        if (run == 1) begin
          if (first < 0) first = c;
          else if (second < 0) second = c;
        end
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
      ce = ~ce;
    end
    checks++;
    if (second - first != 1600) begin
      errors++;
      $display("FAIL half_rate_period got=%0d want=1600", second - first);
    end
    checks++;
    if (max_run != 1) begin
      errors++;
      $display("FAIL half_rate_ls_width got=%0d want=1", max_run);
    end
  endtask

  task automatic test_pipe3();
    int hs_at = -1;
    int fall_at = -1;
    logic prev_de = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if (act[2] !== cur[2]) begin
        errors++;
        $display("FAIL pipe3 c=%0d got=%h want=%h", c, act[2], cur[2]);
      end
      if (hs_at < 0 && act[2].hs === 1'b1) hs_at = int'(act[2].hpos);
      if (fall_at < 0 && prev_de === 1'b1 && act[2].de === 1'b0)
        fall_at = int'(act[2].hpos);
      prev_de = act[2].de;
    end
    checks++;
    if (hs_at != 13) begin
      errors++;
      $display("FAIL pipe3_hsync hpos got=%0d want=13", hs_at);
    end
    checks++;
    if (fall_at != 11) begin
      errors++;
      $display("FAIL pipe3_de_fall hpos got=%0d want=11", fall_at);
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    for (int c = 0; c < 395; c++) tick();
    checks++;
    if (act[1].hpos !== 10'd5 || act[1].vpos !== 10'd4 || act[1].fc !== 12'd2)
    begin
      errors++;
      $display("FAIL mid_pre h=%0d v=%0d f=%0d want 5 4 2",
               act[1].hpos, act[1].vpos, act[1].fc);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (act[1] !== RST_LOWPOL) begin
      errors++;
      $display("FAIL mid_reset got=%h want=%h", act[1], RST_LOWPOL);
    end
    checks++;
    if (act[0].hpos !== 10'd0 || act[0].vpos !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_def h=%0d v=%0d want 0 0",
               act[0].hpos, act[0].vpos);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (act[1] !== cur[1]) begin
        errors++;
        $display("FAIL mid_resume c=%0d got=%h want=%h", c, act[1], cur[1]);
      end
    end
    checks++;
    if (act[1].hpos !== 10'd5 || act[1].vpos !== 10'd1) begin
      errors++;
      $display("FAIL mid_resume_pos h=%0d v=%0d want 5 1",
               act[1].hpos, act[1].vpos);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b0;
    #1;
    test_reset();
    test_default_line();
    test_frames();
    test_frame_wrap();
    test_half_rate();
    test_pipe3();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
